// File: rtl/video_pkg.sv
// Shared video-datapath definitions.
//   PIX_W   : default pixel width
//   NUM_CH  : number of demux output channels
//   state_t : line-steering state (IDLE = between lines, LOCKED = mid-line)
package video_pkg;

  localparam int PIX_W  = 16;
  localparam int NUM_CH = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1x4_nbits_stream_if.sv
// Bundle of the pixel-stream signals around the 1:4 demux.
//   Upstream  : s0, s1, x_in, in_valid, in_last -> block; in_ready <- block
//   Downstream: y0..y3, out_valid[3:0], out_last[3:0] <- block; out_ready[3:0] -> block
//   Status    : beat_cnt, busy <- block
// modport master = the side that feeds the stream and consumes the channels,
// modport slave  = the demux itself.
interface demux_1x4_nbits_stream_if
  import video_pkg::*;
#(
  parameter int N     = PIX_W,
  parameter int CNT_W = 12
);

  logic             s0;
  logic             s1;
  logic [N-1:0]     x_in;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [N-1:0]     y0;
  logic [N-1:0]     y1;
  logic [N-1:0]     y2;
  logic [N-1:0]     y3;
  logic [3:0]       out_valid;
  logic [3:0]       out_last;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy;

  modport master (
    output s0, s1, x_in, in_valid, in_last, out_ready,
    input  in_ready, y0, y1, y2, y3, out_valid, out_last, beat_cnt, busy
  );

  modport slave (
    input  s0, s1, x_in, in_valid, in_last, out_ready,
    output in_ready, y0, y1, y2, y3, out_valid, out_last, beat_cnt, busy
  );

endinterface

// File: rtl/stream_out_reg.sv
// One-entry valid/ready holding register for a single output channel.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din this cycle (wins over drain)
//   din      : {last, data}; the flag occupies the MSB
//   drain    : downstream ready for this channel
//   dout     : held {last, data}
//   valid    : entry is occupied
module stream_out_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         drain,
  output logic [W-1:0] dout,
  output logic         valid
);

  logic [W-1:0] data_reg;
  logic         valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= din;
      valid_reg <= 1'b1;
    end else if (drain) begin
      // Pixel data is left in place; only the last flag is retired
      // together with valid.
      valid_reg       <= 1'b0;
      data_reg[W-1]   <= 1'b0;
    end
  end

  assign dout  = data_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/demux_1x4_nbits_stream.sv
// Registered 1:4 pixel-stream demultiplexer. Each line (packet terminated by
// in_last) is steered whole to the channel chosen by {s1,s0} on its first
// beat; the choice is held until the last beat.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream interface (slave view), see demux_1x4_nbits_stream_if
module demux_1x4_nbits_stream
  import video_pkg::*;
#(
  parameter int N     = PIX_W,
  parameter int CNT_W = 12
) (
  input logic                     clk,
  input logic                     rst,
  demux_1x4_nbits_stream_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       tgt;
  logic             in_ready_w;
  logic             acc;

  logic [N:0]        ch_dout [NUM_CH];
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_last;

  // Between lines the live select decides; mid-line the captured one does.
  assign tgt = (state_reg == IDLE) ? {bus.s1, bus.s0} : sel_reg;

  // Only the target channel can stall the input; its slot frees up either
  // when empty or when it drains in the same cycle it is reloaded.
  assign in_ready_w = !rst && (!ch_valid[tgt] || bus.out_ready[tgt]);
  assign acc        = bus.in_valid && in_ready_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 2'b00;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          sel_next   = {bus.s1, bus.s0};
          state_next = bus.in_last ? IDLE : LOCKED;
        end
      end
      LOCKED: begin
        if (acc && bus.in_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (acc) begin
      if (bus.in_last) begin
        cnt_next = '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    stream_out_reg #(
      .W (N + 1)
    ) u_out_reg (
      .clk   (clk),
      .rst   (rst),
      .load  (acc && (tgt == 2'(gi))),
      .din   ({bus.in_last, bus.x_in}),
      .drain (bus.out_ready[gi]),
      .dout  (ch_dout[gi]),
      .valid (ch_valid[gi])
    );
    assign ch_last[gi] = ch_dout[gi][N];
  end

  assign bus.y0        = ch_dout[0][N-1:0];
  assign bus.y1        = ch_dout[1][N-1:0];
  assign bus.y2        = ch_dout[2][N-1:0];
  assign bus.y3        = ch_dout[3][N-1:0];
  assign bus.out_valid = ch_valid;
  assign bus.out_last  = ch_last;
  assign bus.in_ready  = in_ready_w;
  assign bus.beat_cnt  = cnt_reg;
  assign bus.busy      = (state_reg == LOCKED);

endmodule

// File: tb/tb_demux_1x4_nbits_stream.sv
// Self-checking bench for demux_1x4_nbits_stream. Two instances share one
// stimulus stream: the default build (CNT_W=12) and a narrow counter build
// (CNT_W=3) used to exercise beat_cnt saturation.
module tb_demux_1x4_nbits_stream;

  logic        clk;
  logic        rst;
  logic [1:0]  t_s;
  logic [15:0] t_x;
  logic        t_valid;
  logic        t_last;
  logic [3:0]  t_ordy;

  int total = 0;
  int bad   = 0;

  // Reference: one slot per channel, plus line-level bookkeeping.
  bit        m_vld  [4];
  bit        m_lst  [4];
  bit [15:0] m_y    [4];
  bit        m_busy;
  bit [1:0]  m_sel;
  int        m_beats;

  demux_1x4_nbits_stream_if #(.N(16), .CNT_W(12)) bus_a ();
  demux_1x4_nbits_stream_if #(.N(16), .CNT_W(3))  bus_b ();

  assign bus_a.s0 = t_s[0];  assign bus_b.s0 = t_s[0];
  assign bus_a.s1 = t_s[1];  assign bus_b.s1 = t_s[1];
  assign bus_a.x_in = t_x;   assign bus_b.x_in = t_x;
  assign bus_a.in_valid = t_valid;  assign bus_b.in_valid = t_valid;
  assign bus_a.in_last = t_last;    assign bus_b.in_last = t_last;
  assign bus_a.out_ready = t_ordy;  assign bus_b.out_ready = t_ordy;

  demux_1x4_nbits_stream #(.N(16), .CNT_W(12)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  demux_1x4_nbits_stream #(.N(16), .CNT_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_vld[k] = 1'b0;
      m_lst[k] = 1'b0;
      m_y[k]   = 16'h0;
    end
    m_busy  = 1'b0;
    m_sel   = 2'b00;
    m_beats = 0;
  endtask

  // One clock cycle: drive inputs mid-cycle, compare the DUT state left by
  // the previous edge, then advance the model as the coming edge will.
  task automatic step(input bit r, input bit [1:0] s, input bit [15:0] x,
                      input bit v, input bit l, input bit [3:0] ordy,
                      output bit accepted);
    bit [1:0] tgt;
    bit       rdy;
    bit       acc;
    bit [3:0] e_vld;
    bit [3:0] e_lst;
    @(negedge clk);
    rst = r; t_s = s; t_x = x; t_valid = v; t_last = l; t_ordy = ordy;
    #1;
    tgt = m_busy ? m_sel : s;
    rdy = !r && (!m_vld[tgt] || ordy[tgt]);
    acc = v && rdy;
    for (int k = 0; k < 4; k++) begin
      e_vld[k] = m_vld[k];
      e_lst[k] = m_lst[k];
    end
    check("in_ready_a", bus_a.in_ready, rdy);
    check("in_ready_b", bus_b.in_ready, rdy);
    check("busy", bus_a.busy, m_busy);
    check("beat_cnt_a", bus_a.beat_cnt, (m_beats > 4095) ? 4095 : m_beats);
    check("beat_cnt_b", bus_b.beat_cnt, (m_beats > 7) ? 7 : m_beats);
    check("out_valid", bus_a.out_valid, e_vld);
    check("out_valid_b", bus_b.out_valid, e_vld);
    check("out_last", bus_a.out_last, e_lst);
    check("y0", bus_a.y0, m_y[0]);
    check("y1", bus_a.y1, m_y[1]);
    check("y2", bus_a.y2, m_y[2]);
    check("y3", bus_a.y3, m_y[3]);
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc && tgt == k[1:0]) begin
          m_vld[k] = 1'b1;
          m_lst[k] = l;
          m_y[k]   = x;
        end else if (ordy[k]) begin
          m_vld[k] = 1'b0;
          m_lst[k] = 1'b0;
        end
      end
      if (acc) begin
        if (!m_busy) m_sel = tgt;
        m_busy  = !l;
        m_beats = l ? 0 : m_beats + 1;
      end
    end
    accepted = acc;
  endtask

  // Offer one beat until it is taken, with a bounded wait.
  task automatic send(input bit [1:0] s, input bit [15:0] x, input bit l, input bit [3:0] ordy);
    bit a;
    int n;
    n = 0;
    do begin
      step(1'b0, s, x, 1'b1, l, ordy, a);
      n++;
    end while (!a && n < 64);
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input bit [3:0] ordy);
    bit a;
    step(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, ordy, a);
  endtask

  initial begin
    bit a;
    bit [1:0] rs;
    rst = 1'b1; t_s = 2'b00; t_x = 16'h0; t_valid = 1'b0; t_last = 1'b0; t_ordy = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset then idle
    step(1'b1, 2'b00, 16'h0, 1'b0, 1'b0, 4'hF, a);
    idle(4'hF);
    check("rst_out_valid", bus_a.out_valid, 4'b0000);
    check("rst_y0", bus_a.y0, 16'h0);
    check("idle_in_ready", bus_a.in_ready, 1'b1);
    check("idle_busy", bus_a.busy, 1'b0);

    // Single-beat lines to each channel on consecutive cycles
    send(2'b00, 16'hAAAA, 1'b1, 4'hF);
    send(2'b01, 16'hBBBB, 1'b1, 4'hF);
    send(2'b10, 16'hCCCC, 1'b1, 4'hF);
    send(2'b11, 16'hDDDD, 1'b1, 4'hF);
    check("single_y0", bus_a.y0, 16'hAAAA);
    check("single_y1", bus_a.y1, 16'hBBBB);
    check("single_y2", bus_a.y2, 16'hCCCC);
    idle(4'hF);
    check("single_y3", bus_a.y3, 16'hDDDD);
    check("single_last3", bus_a.out_last, 4'b1000);

    // Select lock: select changes mid-line must be ignored
    send(2'b10, 16'h1111, 1'b0, 4'hF);
    send(2'b01, 16'h2222, 1'b0, 4'hF);
    check("lock_y2_b0", bus_a.y2, 16'h1111);
    send(2'b01, 16'h3333, 1'b0, 4'hF);
    send(2'b01, 16'h4444, 1'b1, 4'hF);
    check("lock_cnt3", bus_a.beat_cnt, 12'd3);
    idle(4'hF);
    check("lock_y2_last", bus_a.y2, 16'h4444);
    check("lock_valid", bus_a.out_valid, 4'b0100);
    check("lock_busy", bus_a.busy, 1'b0);
    check("lock_y1_untouched", bus_a.y1, 16'hBBBB);

    // Backpressure on ch1, then a line to ch3
    send(2'b01, 16'h5A5A, 1'b0, 4'b1101);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 16'h6B6B, 1'b1, 1'b1, 4'b1101, a);
    check("bp_hold_in_ready", bus_a.in_ready, 1'b0);
    check("bp_hold_y1", bus_a.y1, 16'h5A5A);
    send(2'b11, 16'h6B6B, 1'b1, 4'hF);
    send(2'b11, 16'h7C7C, 1'b1, 4'hF);
    idle(4'hF);
    check("bp_y3", bus_a.y3, 16'h7C7C);

    // Reset mid-line
    send(2'b00, 16'h0101, 1'b0, 4'hF);
    send(2'b00, 16'h0202, 1'b0, 4'hF);
    step(1'b1, 2'b00, 16'h0303, 1'b1, 1'b0, 4'hF, a);
    idle(4'hF);
    check("mid_rst_valid", bus_a.out_valid, 4'b0000);
    check("mid_rst_busy", bus_a.busy, 1'b0);
    send(2'b11, 16'h5555, 1'b1, 4'hF);
    idle(4'hF);
    check("post_rst_y3", bus_a.y3, 16'h5555);

    // Saturation of the narrow counter on a 10-beat line
    for (int i = 0; i < 9; i++) send(2'b00, 16'(i), 1'b0, 4'hF);
    idle(4'hF);
    check("sat_b", bus_b.beat_cnt, 3'd7);
    check("sat_a", bus_a.beat_cnt, 12'd9);
    send(2'b00, 16'h0009, 1'b1, 4'hF);
    idle(4'hF);
    check("sat_clear_b", bus_b.beat_cnt, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0), rs, 16'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
           {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)}, a);
    end
    idle(4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1x4_nbits_stream.md
Name: demux_1x4_nbits_stream

Overview:
- Registered 1-to-4 pixel-stream demultiplexer; the inverse of the 4:1 n-bit select mux in the video datapath.
- Takes one N-bit pixel stream with valid/ready/last (one line = one packet) and steers each line to one of four downstream channels chosen by {s1,s0}.
- The select is sampled on the first beat of a line and held until its last beat, so a line is never split across channels.
- Each channel has a one-entry output register with its own valid/ready, so one stalled channel does not block a line routed elsewhere.

Parameters:
- N, 16, pixel data width.
- CNT_W, 12, width of the beat counter; max line length counted is 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s0  in  1  select LSB, sampled only on first beat of a line.
- s1  in  1  select MSB, sampled only on first beat of a line.
- x_in  in  N  input pixel.
- in_valid  in  1  x_in/in_last valid.
- in_last  in  1  final beat of current line.
- in_ready  out  1  block accepts beat this cycle (combinational).
- y0, y1, y2, y3  out  N each  channel data outputs.
- out_valid  out  4  per-channel valid; bit k belongs to yk.
- out_last  out  4  per-channel last flag; bit k belongs to yk.
- out_ready  in  4  per-channel downstream ready.
- beat_cnt  out  CNT_W  beats accepted so far in current line.
- busy  out  1  high while a line is in progress (state LOCKED).

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, sel_q=0, y0..y3=0, out_valid=0, out_last=0, beat_cnt=0, busy=0. in_ready=0 while rst is high. Any partial line is discarded.
- Target channel: tgt = {s1,s0} in IDLE; tgt = sel_q in LOCKED.
- in_ready = !rst && (!out_valid[tgt] || out_ready[tgt]).
- Accept: acc = in_valid && in_ready.
- FSM:
  - IDLE: on acc, sel_q <= {s1,s0}. If !in_last, go to LOCKED; otherwise stay in IDLE (single-beat line).
  - LOCKED: s0/s1 are ignored. On acc with in_last, go to IDLE.
  - busy = (state==LOCKED).
- Channel register k:
  - On acc && tgt==k: yk <= x_in, out_valid[k] <= 1, out_last[k] <= in_last.
  - Otherwise, if out_ready[k]: out_valid[k] <= 0, out_last[k] <= 0. yk holds its last value.
  - Simultaneous drain and load on the same channel: the load wins, giving full throughput of 1 beat/cycle.
- Latency: an accepted beat appears on its channel exactly 1 cycle later.
- Non-target channels drain independently and are never blocked by tgt.
- beat_cnt:
  - On acc && in_last, goes to 0.
  - On acc && !in_last, increments and saturates at 2^CNT_W-1 (no wrap).
  - Otherwise holds.
- in_valid low mid-line: stay LOCKED and keep sel_q; the bubble is tolerated.
- out_valid[k] stays asserted with yk/out_last[k] stable until out_ready[k].

Decomposition:
- Shared package (video_pkg):
  - Pixel width constant PIX_W=16.
  - Channel-count constant NUM_CH=4.
  - State enum {IDLE, LOCKED}.
- One natural sub-module: stream_out_reg, a one-entry valid/ready holding register of width N+1 (data+last), instantiated four times.
- Top level holds the FSM, tgt mux, in_ready logic and beat_cnt.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all y=0, out_valid=0000, in_ready=0. After release with out_ready=1111 -> in_ready=1, busy=0.
- Single-beat lines, all ready:
  - Stimulus: x_in=AAAA/BBBB/CCCC/DDDD with in_last=1 and {s1,s0}=00/01/10/11 on consecutive cycles.
  - Response: each value appears one cycle later on y0/y1/y2/y3 respectively, with out_last set.
- Select lock:
  - Stimulus: 4-beat line 1111,2222,3333,4444 with s=10 on beat 0, then s toggled to 01 on beats 1-3.
  - Response: all beats appear on y2 only; beat_cnt goes 1,2,3,0; busy drops after beat 3.
- Backpressure:
  - Stimulus: out_ready[1]=0 during a 2-beat line to ch1.
  - Response: first beat is held on y1; in_ready=0 until out_ready[1]=1. A concurrent line to ch3 with out_ready[3]=1 after that line completes flows unaffected.
- Reset mid-line:
  - Stimulus: rst asserted after beat 2 of a line to ch0.
  - Response: out_valid=0000 and busy=0. The next line with s=11 routes to y3.
- Counter saturation: CNT_W=3, 10-beat line -> beat_cnt stops at 7, then returns to 0 on the last beat.
